// File: rtl/cdec8_dbg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cdec8_dbg_pkg
// Function : Shared types and helpers for the CDEC8 debug-monitor scanner.
// Revision : 1.0 - initial release
// ============================================================================
package cdec8_dbg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPT    = 3'd1,
        ST_SEND_HI = 3'd2,
        ST_SEND_LO = 3'd3,
        ST_SEND_SP = 3'd4,
        ST_SEND_CR = 3'd5,
        ST_SEND_LF = 3'd6,
        ST_FIN     = 3'd7
    } state_t;

    localparam logic [7:0] c_ascii_sp = 8'h20;
    localparam logic [7:0] c_ascii_cr = 8'h0D;
    localparam logic [7:0] c_ascii_lf = 8'h0A;

    // Uppercase ASCII hex digit for one nibble.
    function automatic logic [7:0] nib_to_hex(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'd0, nib};
        end
        return 8'h37 + {4'd0, nib};
    endfunction

endpackage
`default_nettype wire

// File: rtl/dbg_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : dbg_uart_tx
// Function : 8N1 UART transmitter, LSB first, CLK_DIV clocks per bit.
// Revision : 1.0 - initial release
// ============================================================================
module dbg_uart_tx #(
    parameter int CLK_DIV = 434
) (
    input  logic       clock,
    input  logic       reset_N,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       txd
);

    localparam logic [15:0] c_baud_last = 16'(CLK_DIV - 1);

    logic        r_busy;
    logic [15:0] r_baud_cnt;
    logic [3:0]  r_bit_cnt;
    logic [9:0]  r_shift;

    // The line level is the LSB of the frame register, so txd stays a
    // flop output and the start bit appears on the accepting edge.
    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            r_busy     <= 1'b0;
            r_baud_cnt <= 16'd0;
            r_bit_cnt  <= 4'd0;
            r_shift    <= '1;
        end else if (!r_busy) begin
            if (tx_valid) begin
                r_busy     <= 1'b1;
                r_baud_cnt <= 16'd0;
                r_bit_cnt  <= 4'd0;
                r_shift    <= {1'b1, tx_data, 1'b0};
            end
        end else if (r_baud_cnt == c_baud_last) begin
            r_baud_cnt <= 16'd0;
            if (r_bit_cnt == 4'd9) begin
                r_busy  <= 1'b0;
                r_shift <= '1;
            end else begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
                r_shift   <= {1'b1, r_shift[9:1]};
            end
        end else begin
            r_baud_cnt <= r_baud_cnt + 16'd1;
        end
    end

    assign tx_ready = !r_busy;
    assign txd      = r_shift[0];

endmodule
`default_nettype wire

// File: rtl/cdec8_dbg_scan.sv
`default_nettype none
// ============================================================================
// Module   : cdec8_dbg_scan
// Function : Scans resource bus 0..NUM_RES-1 and prints it as hex over UART.
// Revision : 1.0 - initial release
// ============================================================================
module cdec8_dbg_scan #(
    parameter int CLK_DIV = 434,
    parameter int NUM_RES = 16
) (
    input  logic       clock,
    input  logic       reset_N,
    input  logic       start,
    output logic [7:0] resad,
    input  logic [7:0] resdt,
    output logic       txd,
    output logic       busy,
    output logic       done
);

    import cdec8_dbg_pkg::*;

    localparam logic [7:0] c_last_res = 8'(NUM_RES - 1);

    state_t     r_state;
    logic [7:0] r_dreg;
    logic       r_tx_valid;
    logic [7:0] r_tx_data;
    logic       w_tx_ready;
    logic [7:0] w_char;

    always_comb begin
        w_char = c_ascii_sp;
        case (r_state)
            ST_SEND_HI: w_char = nib_to_hex(r_dreg[7:4]);
            ST_SEND_LO: w_char = nib_to_hex(r_dreg[3:0]);
            ST_SEND_CR: w_char = c_ascii_cr;
            ST_SEND_LF: w_char = c_ascii_lf;
            default:    w_char = c_ascii_sp;
        endcase
    end

    // Each SEND state presents its character one clock after entry and
    // holds it until the transmitter accepts; CAPT fits inside the
    // previous character's line time.
    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            r_state    <= ST_IDLE;
            resad      <= 8'h00;
            busy       <= 1'b0;
            done       <= 1'b0;
            r_dreg     <= 8'h00;
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'h00;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        resad   <= 8'h00;
                        busy    <= 1'b1;
                        r_state <= ST_CAPT;
                    end
                end
                ST_CAPT: begin
                    r_dreg  <= resdt;
                    r_state <= ST_SEND_HI;
                end
                ST_FIN: begin
                    if (w_tx_ready) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        resad   <= 8'h00;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    if (!r_tx_valid) begin
                        r_tx_valid <= 1'b1;
                        r_tx_data  <= w_char;
                    end else if (w_tx_ready) begin
                        r_tx_valid <= 1'b0;
                        case (r_state)
                            ST_SEND_HI: r_state <= ST_SEND_LO;
                            ST_SEND_LO: r_state <= ST_SEND_SP;
                            ST_SEND_SP: begin
                                if (resad == c_last_res) begin
                                    r_state <= ST_SEND_CR;
                                end else begin
                                    resad   <= resad + 8'd1;
                                    r_state <= ST_CAPT;
                                end
                            end
                            ST_SEND_CR: r_state <= ST_SEND_LF;
                            default:    r_state <= ST_FIN;
                        endcase
                    end
                end
            endcase
        end
    end

    dbg_uart_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_uart_tx (
        .clock    (clock),
        .reset_N  (reset_N),
        .tx_valid (r_tx_valid),
        .tx_data  (r_tx_data),
        .tx_ready (w_tx_ready),
        .txd      (txd)
    );

endmodule
`default_nettype wire

// File: tb/tb_cdec8_dbg_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdec8_dbg_scan
// Function : Self-checking bench for cdec8_dbg_scan with a UART line decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdec8_dbg_scan;

    localparam int D     = 4;
    localparam int NR    = 16;
    localparam int PITCH = 10 * D + 1;

    logic       clk     = 1'b0;
    logic       reset_N = 1'b0;
    logic       start0  = 1'b0;
    logic       start1  = 1'b0;
    logic [7:0] resad0, resdt0, resad1, resdt1;
    logic       txd0, busy0, done0, txd1, busy1, done1;
    logic [7:0] tbl [256];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign resdt0 = tbl[resad0];
    assign resdt1 = 8'hF0;

    cdec8_dbg_scan #(.CLK_DIV(D), .NUM_RES(NR)) dut (
        .clock(clk), .reset_N(reset_N), .start(start0), .resad(resad0),
        .resdt(resdt0), .txd(txd0), .busy(busy0), .done(done0)
    );

    cdec8_dbg_scan #(.CLK_DIV(D), .NUM_RES(1)) dut1 (
        .clock(clk), .reset_N(reset_N), .start(start1), .resad(resad1),
        .resdt(resdt1), .txd(txd1), .busy(busy1), .done(done1)
    );

    // UART line decoder and handshake monitor, sampled on the falling edge
    logic [1:0] txd_bus, done_bus, busy_bus;
    assign txd_bus  = {txd1, txd0};
    assign done_bus = {done1, done0};
    assign busy_bus = {busy1, busy0};

    bit         rx_act [2];
    int         rx_k [2];
    int         rx_st [2];
    logic [9:0] rx_sh [2];
    logic       rx_bit [2];
    logic       prev [2] = '{1'b1, 1'b1};
    logic       busy_prev [2];
    int         done_cnt [2];
    int         done_cyc [2];
    int         bit_err = 0;
    int         done_busy_bad = 0;
    int         resad1_bad = 0;
    logic [7:0] rxq0 [$];
    logic [7:0] rxq1 [$];
    int         stq0 [$];
    logic [7:0] exp_q [$];
    string      hexdig = "0123456789ABCDEF";

    always @(negedge clk) begin : mon
        logic t;
        for (int c = 0; c < 2; c++) begin
            t = txd_bus[c];
            if (!reset_N) begin
                rx_act[c] = 1'b0;
            end else begin
                if (!rx_act[c] && prev[c] === 1'b1 && t === 1'b0) begin
                    rx_act[c] = 1'b1;
                    rx_k[c]   = 0;
                    rx_st[c]  = cyc;
                end
                if (rx_act[c]) begin
                    if (rx_k[c] % D == 0) rx_bit[c] = t;
                    else if (t !== rx_bit[c]) bit_err++;
                    if (rx_k[c] % D == D - 1) rx_sh[c][rx_k[c] / D] = rx_bit[c];
                    if (rx_k[c] == 10 * D - 1) begin
                        if (rx_sh[c][0] !== 1'b0 || rx_sh[c][9] !== 1'b1) bit_err++;
                        if (c == 0) begin
                            rxq0.push_back(rx_sh[c][8:1]);
                            stq0.push_back(rx_st[c]);
                        end else begin
                            rxq1.push_back(rx_sh[c][8:1]);
                        end
                        rx_act[c] = 1'b0;
                    end else begin
                        rx_k[c]++;
                    end
                end
            end
            prev[c] = t;
            if (done_bus[c] === 1'b1) begin
                done_cnt[c]++;
                done_cyc[c] = cyc;
                if (busy_bus[c] !== 1'b0 || busy_prev[c] !== 1'b1) done_busy_bad++;
            end
            busy_prev[c] = busy_bus[c];
        end
        if (resad1 !== 8'h00) resad1_bad++;
    end

    // Reference frame: two uppercase hex digits and a space per resource, then CR LF
    task automatic build_exp(input int n, input bit fixed, input logic [7:0] fval);
        exp_q.delete();
        for (int a = 0; a < n; a++) begin
            logic [7:0] v;
            v = fixed ? fval : tbl[a];
            exp_q.push_back(hexdig[v / 16]);
            exp_q.push_back(hexdig[v % 16]);
            exp_q.push_back(8'd32);
        end
        exp_q.push_back(8'd13);
        exp_q.push_back(8'd10);
    endtask

    function automatic int first_diff(input logic [7:0] a [$], input logic [7:0] b [$]);
        int n;
        n = (a.size() > b.size()) ? a.size() : b.size();
        for (int i = 0; i < n; i++) begin
            if (i >= a.size() || i >= b.size()) return i;
            if (a[i] !== b[i]) return i;
        end
        return -1;
    endfunction

    function automatic int byte_at(input logic [7:0] q [$], input int i);
        if (i >= 0 && i < q.size()) return int'(q[i]);
        return -1;
    endfunction

    task automatic clear_mon();
        rxq0.delete();
        rxq1.delete();
        stq0.delete();
        bit_err       = 0;
        done_busy_bad = 0;
        resad1_bad    = 0;
    endtask

    task automatic pulse0(output int c0);
        @(posedge clk); #1;
        start0 = 1'b1;
        c0 = cyc + 1;
        @(posedge clk); #1;
        start0 = 1'b0;
    endtask

    task automatic pulse1();
        @(posedge clk); #1;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
    endtask

    task automatic wait_done(input int ch, input int n_before, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (done_cnt[ch] != n_before) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic scan0(output bit ok);
        int n, c0;
        n = done_cnt[0];
        pulse0(c0);
        wait_done(0, n, ok);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({resad0, txd0, busy0, done0} !== {8'h00, 1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset0: resad=%h txd=%b busy=%b done=%b want 00 1 0 0", resad0, txd0, busy0, done0);
        end
        total++;
        if ({resad1, txd1, busy1, done1} !== {8'h00, 1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset1: resad=%h txd=%b busy=%b done=%b want 00 1 0 0", resad1, txd1, busy1, done1);
        end
        reset_N = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        total++;
        if ({busy0, txd0} !== 2'b01) begin
            bad++;
            $display("FAIL idle_after_reset: busy=%b txd=%b want 0 1", busy0, txd0);
        end
    endtask

    task automatic test_single_scan();
        bit ok;
        int n, d;
        clear_mon();
        build_exp(NR, 1'b0, 8'h00);
        n = done_cnt[0];
        scan0(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL single_timeout: done=0 want 1"); end
        repeat (60) @(posedge clk);
        #1;
        d = first_diff(rxq0, exp_q);
        total++;
        if (d != -1) begin
            bad++;
            $display("FAIL single_frame: byte %0d got %0d want %0d (len %0d/%0d)",
                     d, byte_at(rxq0, d), byte_at(exp_q, d), rxq0.size(), exp_q.size());
        end
        total++;
        if (done_cnt[0] - n != 1) begin bad++; $display("FAIL single_done_count: got %0d want 1", done_cnt[0] - n); end
        total++;
        if (done_busy_bad != 0) begin bad++; $display("FAIL single_done_busy: got %0d want 0", done_busy_bad); end
        total++;
        if (bit_err != 0) begin bad++; $display("FAIL single_bit_err: got %0d want 0", bit_err); end
        total++;
        if (resad0 !== 8'h00) begin bad++; $display("FAIL single_resad_end: got %h want 00", resad0); end
    endtask

    task automatic test_bit_timing();
        bit ok;
        int n, c0, badp, first;
        clear_mon();
        n = done_cnt[0];
        @(posedge clk); #1;
        start0 = 1'b1;
        c0 = cyc + 1;
        @(posedge clk); #1;
        start0 = 1'b0;
        total++;
        if ({busy0, resad0} !== {1'b1, 8'h00}) begin
            bad++;
            $display("FAIL timing_clk0: busy=%b resad=%h want 1 00", busy0, resad0);
        end
        wait_done(0, n, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL timing_timeout: done=0 want 1"); end
        first = (stq0.size() > 0) ? stq0[0] : -1;
        total++;
        if (first != c0 + 3) begin bad++; $display("FAIL timing_first_start: got %0d want %0d", first, c0 + 3); end
        badp = -1;
        for (int i = 0; i + 1 < stq0.size(); i++) begin
            if (badp < 0 && stq0[i + 1] - stq0[i] != PITCH) badp = i;
        end
        total++;
        if (badp >= 0 || stq0.size() != 3 * NR + 2) begin
            bad++;
            $display("FAIL timing_pitch: char %0d pitch %0d want %0d (chars %0d)", badp,
                     (badp >= 0) ? stq0[badp + 1] - stq0[badp] : 0, PITCH, stq0.size());
        end
        total++;
        if (stq0.size() == 0 || done_cyc[0] != stq0[stq0.size() - 1] + PITCH) begin
            bad++;
            $display("FAIL timing_done: got %0d want last start + %0d", done_cyc[0], PITCH);
        end
        total++;
        if (bit_err != 0) begin bad++; $display("FAIL timing_bit_width: got %0d want 0", bit_err); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int n, c0, e, d, s2;
        clear_mon();
        build_exp(NR, 1'b0, 8'h00);
        exp_q = {exp_q, exp_q};
        n = done_cnt[0];
        pulse0(c0);
        for (int i = 0; i < 3000 && stq0.size() < 5; i++) begin @(posedge clk); #1; end
        pulse0(c0);
        for (int i = 0; i < 3000 && stq0.size() < 30; i++) begin @(posedge clk); #1; end
        pulse0(c0);
        for (int i = 0; i < 3000 && stq0.size() < 50; i++) begin @(posedge clk); #1; end
        e = (stq0.size() >= 50) ? stq0[49] + PITCH : cyc + 10;
        for (int i = 0; i < 200 && cyc < e - 1; i++) begin @(posedge clk); #1; end
        start0 = 1'b1;
        @(posedge clk); #1;
        total++;
        if (done0 !== 1'b1 || cyc != e) begin
            bad++;
            $display("FAIL b2b_done_edge: done=%b at %0d want 1 at %0d", done0, cyc, e);
        end
        @(posedge clk); #1;
        start0 = 1'b0;
        total++;
        if (busy0 !== 1'b1) begin bad++; $display("FAIL b2b_restart: busy=%b want 1", busy0); end
        wait_done(0, n + 1, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL b2b_timeout: done=0 want 1"); end
        repeat (100) @(posedge clk);
        #1;
        d = first_diff(rxq0, exp_q);
        total++;
        if (d != -1) begin
            bad++;
            $display("FAIL b2b_frames: byte %0d got %0d want %0d (len %0d/%0d)",
                     d, byte_at(rxq0, d), byte_at(exp_q, d), rxq0.size(), exp_q.size());
        end
        s2 = (stq0.size() > 50) ? stq0[50] : -1;
        total++;
        if (s2 != e + 4) begin bad++; $display("FAIL b2b_second_start: got %0d want %0d", s2, e + 4); end
        total++;
        if (done_cnt[0] - n != 2 || busy0 !== 1'b0) begin
            bad++;
            $display("FAIL b2b_done_count: got %0d busy=%b want 2 busy=0", done_cnt[0] - n, busy0);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit ok, found;
        int n, c0, d;
        clear_mon();
        build_exp(NR, 1'b0, 8'h00);
        n = done_cnt[0];
        pulse0(c0);
        found = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (stq0.size() == 19 && rx_act[0] && cyc == rx_st[0] + 4) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        total++;
        if (!found) begin bad++; $display("FAIL midreset_reach: char 20 not reached"); end
        reset_N = 1'b0;
        #1;
        total++;
        if ({txd0, busy0, resad0, done0} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
            bad++;
            $display("FAIL midreset_async: txd=%b busy=%b resad=%h done=%b want 1 0 00 0",
                     txd0, busy0, resad0, done0);
        end
        repeat (3) @(posedge clk);
        #1;
        clear_mon();
        reset_N = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        total++;
        if (busy0 !== 1'b0 || rxq0.size() != 0 || done_cnt[0] != n) begin
            bad++;
            $display("FAIL midreset_idle: busy=%b chars=%0d dones=%0d want 0 0 0",
                     busy0, rxq0.size(), done_cnt[0] - n);
        end
        scan0(ok);
        total++;
        if (!ok) begin bad++; $display("FAIL midreset_timeout: done=0 want 1"); end
        d = first_diff(rxq0, exp_q);
        total++;
        if (d != -1 || bit_err != 0) begin
            bad++;
            $display("FAIL midreset_frame: byte %0d got %0d want %0d bit_err=%0d",
                     d, byte_at(rxq0, d), byte_at(exp_q, d), bit_err);
        end
    endtask

    task automatic test_single_resource();
        bit ok;
        int n, d;
        clear_mon();
        build_exp(1, 1'b1, 8'hF0);
        n = done_cnt[1];
        pulse1();
        wait_done(1, n, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL one_res_timeout: done=0 want 1"); end
        repeat (10) @(posedge clk);
        #1;
        d = first_diff(rxq1, exp_q);
        total++;
        if (d != -1) begin
            bad++;
            $display("FAIL one_res_frame: byte %0d got %0d want %0d (len %0d/%0d)",
                     d, byte_at(rxq1, d), byte_at(exp_q, d), rxq1.size(), exp_q.size());
        end
        total++;
        if (resad1_bad != 0) begin bad++; $display("FAIL one_res_resad: nonzero samples %0d want 0", resad1_bad); end
    endtask

    task automatic test_hex_edges();
        logic [7:0] hv [4];
        bit ok;
        int d;
        hv = '{8'h00, 8'h09, 8'h0A, 8'hFF};
        for (int k = 0; k < 4; k++) begin
            for (int a = 0; a < 256; a++) tbl[a] = hv[k];
            build_exp(NR, 1'b0, 8'h00);
            clear_mon();
            scan0(ok);
            d = first_diff(rxq0, exp_q);
            total++;
            if (!ok || d != -1) begin
                bad++;
                $display("FAIL hex_%h: ok=%b byte %0d got %0d want %0d", hv[k], ok, d,
                         byte_at(rxq0, d), byte_at(exp_q, d));
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        int d;
        for (int k = 0; k < 3; k++) begin
            for (int a = 0; a < 256; a++) tbl[a] = 8'($urandom);
            build_exp(NR, 1'b0, 8'h00);
            repeat ($urandom_range(0, 15)) @(posedge clk);
            clear_mon();
            scan0(ok);
            d = first_diff(rxq0, exp_q);
            total++;
            if (!ok || d != -1 || bit_err != 0) begin
                bad++;
                $display("FAIL random_%0d: ok=%b byte %0d got %0d want %0d bit_err=%0d", k, ok, d,
                         byte_at(rxq0, d), byte_at(exp_q, d), bit_err);
            end
        end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) tbl[a] = 8'(a * 17) ^ 8'h2B;
        test_reset();
        test_single_scan();
        test_bit_timing();
        test_back_to_back();
        test_reset_mid_frame();
        test_single_resource();
        test_hex_edges();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cdec8_dbg_scan.md
# cdec8_dbg_scan

Debug-monitor scanner for the CDEC8 core: on request it walks the datapath resource-observation bus (drives `resad`, samples `resdt`) over resource addresses 0x00 to NUM_RES-1. It formats each byte as two uppercase ASCII hex digits plus a space, ends the line with CR LF, and sends the line out a UART 8N1 transmitter to the host PC. It sits beside the datapath in the FPGA top level and is the consumer end of the `resad`/`resdt` interface.

## Interface
- `CLK_DIV`, 434: clocks per UART bit (50 MHz / 115200); legal range 2..65535.
- `NUM_RES`, 16: resources scanned, addresses 0x00..NUM_RES-1; legal range 1..256.
- `clock`  in  1  single system clock; all state is rising-edge.
- `reset_N`  in  1  asynchronous, active-low reset.
- `start`  in  1  scan request; sampled only while idle.
- `resad`  out  8  resource address to the datapath observation mux; registered.
- `resdt`  in  8  resource data, combinational from `resad`.
- `txd`  out  1  UART serial out; idle high; registered.
- `busy`  out  1  high from the clock after `start` is accepted until `done`.
- `done`  out  1  one-clock pulse when the last stop bit completes.

Reset values: `resad`=0x00, `txd`=1, `busy`=0, `done`=0.

## Operation
- FSM states: IDLE, CAPT, SEND_HI, SEND_LO, SEND_SP, SEND_CR, SEND_LF, FIN.
- IDLE: `start`=1 → `resad`=0x00, `busy`=1, go to CAPT. `start` in any other state is ignored.
- CAPT: latch `resdt` into `dreg` (one full clock after `resad` changed), go to SEND_HI.
- SEND_HI, SEND_LO: hand hex(`dreg[7:4]`), then hex(`dreg[3:0]`), to the TX sub-module. Hex mapping: nibble 0-9 → 0x30+n; A-F → 0x37+n (uppercase).
- SEND_SP: send 0x20.
  - Not the last resource: increment `resad`, go to CAPT.
  - Last resource (`resad`=NUM_RES-1): go to SEND_CR.
- SEND_CR sends 0x0D. SEND_LF sends 0x0A.
- FIN: wait for the TX to go idle, pulse `done`, drop `busy`, set `resad` to 0x00, go to IDLE.
- Each SEND_* state holds until the TX handshake completes (`tx_valid`&&`tx_ready`).
- Frame length: 3·NUM_RES+2 characters (50 at default).
- `resad` does not increment past NUM_RES-1. At NUM_RES=256 the scan ends on 0xFF with no wrap.

## Timing
- UART format: 8N1, LSB first. Start bit 0, data, stop bit 1. Each bit lasts exactly CLK_DIV clocks.
- Let clock 0 be the edge that samples `start`=1.
  - Clock 0: `busy` and `resad` update.
  - Clock 1: CAPT latches `resdt`.
  - Clock 2: SEND_HI presents the byte.
  - Clock 3 edge: `txd` falls for the first start bit.
- Character pitch is exactly 10·CLK_DIV+1 clocks, start edge to next start edge: the TX spends one idle-high clock re-arming.
- CAPT is hidden inside the SEND_SP character time. It must not widen the pitch of the space→next-digit transition.
- `done` is high for exactly the clock after the final LF stop bit's last clock.
- `start` held high on the `done` clock is ignored; the block is still not in IDLE. `start` on the following clock begins a new scan.
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronous reset), the frame is abandoned, and no partial bit is stretched. After release the block waits in IDLE.

## Structure
- `cdec8_dbg_pkg`: FSM state encoding, ASCII constants (SP 0x20, CR 0x0D, LF 0x0A), and a nibble-to-hex function.
- Sub-module `dbg_uart_tx`.
  - Parameter: CLK_DIV.
  - Ports: `clock`, `reset_N`, `tx_valid`, `tx_data[7:0]`, `tx_ready`, `txd`.
  - Internals: baud counter, 4-bit bit counter, 10-bit shift register.
  - `tx_ready` is high only while idle.
- Top-level module: FSM, `resad` counter, `dreg`.

## Test plan
All scenarios use CLK_DIV=4 and NUM_RES=16. The bench `resdt` model returns `resad`·0x11 XOR 0x2B.

1. Single scan → `txd` decodes to 50 bytes: "2B 3A 09 18 6F 7E 4D 5C A3 B2 81 90 E7 F6 C5 D4 \r\n". `done` pulses once, `busy` drops on the same edge.
2. Bit timing → first `txd` fall is at clock 3. Every bit is exactly 4 clocks. Consecutive start edges are exactly 41 clocks apart.
3. `start` pulsed at characters 5 and 30, and on the `done` clock → all ignored, exactly one frame emitted. `start` one clock after `done` → a second identical frame.
4. `reset_N` low during the data bits of character 20 → same clock: `txd`=1, `busy`=0, `resad`=0x00. After release and `start`, a full correct frame.
5. NUM_RES=1, `resdt`=0xF0 → "F0 \r\n" (5 bytes). `resad` never leaves 0x00.
6. Hex edge values: `resdt` forced to 0x00, 0x09, 0x0A, 0xFF → "00", "09", "0A", "FF" (digits 0x30/0x39/0x41/0x46).
